// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// error codes and frame header width.
package boot_pkg;

    localparam int unsigned HDR_W = 16;

    typedef enum logic [2:0] {
        StHdrLo = 3'd0,
        StHdrHi = 3'd1,
        StData  = 3'd2,
        StCheck = 3'd3,
        StDone  = 3'd4,
        StErr   = 3'd5
    } boot_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/byte_word_packer.sv
// Shifts accepted bytes into a little-endian 32-bit word and pulses word_valid
// for one cycle once the fourth byte of a word has been taken.
module byte_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  data_in,
    input  logic        byte_valid,
    output logic [1:0]  byte_cnt,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear) begin
            cnt_d   = 2'd0;
            shift_d = '0;
        end else if (byte_valid) begin
            // Newest byte enters at the top, so byte0 ends up in [7:0].
            shift_d = {data_in, shift_q[31:8]};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                word_d       = shift_d;
                word_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q        <= 2'd0;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign byte_cnt   = cnt_q;
    assign word       = word_q;
    assign word_valid = word_valid_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory and
// releases the core only after a clean load.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH),
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT - 1);
    localparam logic [HDR_W-1:0]  DEPTH_LIM = HDR_W'(IMEM_DEPTH);

    boot_state_e       state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [HDR_W-1:0]  len_q, len_d;
    logic [7:0]        xor_q, xor_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              hold_q, hold_d;

    logic              xfer, counting, timeout_hit, last_word, pack_clear;
    logic [HDR_W-1:0]  hdr_len;
    logic [1:0]        pack_cnt;

    assign rx_ready    = (state_q == StHdrLo) || (state_q == StHdrHi) ||
                         (state_q == StData)  || (state_q == StCheck);
    assign xfer        = rx_valid & rx_ready;
    assign counting    = (state_q == StHdrHi) || (state_q == StData) || (state_q == StCheck);
    // A byte arriving in the final idle cycle still beats the timeout.
    assign timeout_hit = counting && !xfer && (idle_q == IDLE_MAX);
    assign hdr_len     = {rx_data, len_lo_q};
    assign last_word   = (HDR_W'(word_idx_q) == (len_q - HDR_W'(1)));

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        xor_d      = xor_q;
        word_idx_d = word_idx_q;
        addr_d     = addr_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        hold_d     = hold_q;
        pack_clear = 1'b0;
        idle_d     = (counting && !xfer) ? idle_q + IDLE_W'(1) : '0;

        unique case (state_q)
            StHdrLo: begin
                if (xfer) begin
                    len_lo_d = rx_data;
                    xor_d    = rx_data;
                    state_d  = StHdrHi;
                end
            end
            StHdrHi: begin
                if (xfer) begin
                    xor_d = xor_q ^ rx_data;
                    len_d = hdr_len;
                    if (hdr_len > DEPTH_LIM) begin
                        state_d    = StErr;
                        error_d    = 1'b1;
                        err_code_d = ERR_LEN;
                    end else if (hdr_len == '0) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    xor_d = xor_q ^ rx_data;
                    if (pack_cnt == 2'd3) begin
                        addr_d = word_idx_q;
                        if (last_word) begin
                            word_idx_d = '0;
                            state_d    = StCheck;
                        end else begin
                            word_idx_d = word_idx_q + ADDR_W'(1);
                        end
                    end
                end
            end
            StCheck: begin
                if (xfer) begin
                    if (rx_data == xor_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d    = StErr;
                        error_d    = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            StDone, StErr: begin
                if (start) begin
                    state_d    = StHdrLo;
                    len_lo_d   = '0;
                    len_d      = '0;
                    xor_d      = '0;
                    word_idx_d = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    hold_d     = 1'b1;
                    pack_clear = 1'b1;
                end
            end
            default: state_d = StHdrLo;
        endcase

        if (timeout_hit) begin
            state_d    = StErr;
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StHdrLo;
            len_lo_q   <= '0;
            len_q      <= '0;
            xor_q      <= '0;
            word_idx_q <= '0;
            addr_q     <= '0;
            idle_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            xor_q      <= xor_d;
            word_idx_q <= word_idx_d;
            addr_q     <= addr_d;
            idle_q     <= idle_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            hold_q     <= hold_d;
        end
    end

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pack_clear),
        .data_in    (rx_data),
        .byte_valid (xfer && (state_q == StData)),
        .byte_cnt   (pack_cnt),
        .word       (imem_wdata),
        .word_valid (imem_we)
    );

    assign imem_addr = addr_q;
    assign core_hold = hold_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

endmodule
